genius_seq_player: RTL and testbench
====================================

// Module: genius_seq_player
// PURPOSE
//   Plays back the stored Genius colour sequence to the player. It steps through the
//   sequence RAM and drives the select input of the 4:1 colour-pattern mux
//   (mux4x1_4bits SEL_i). Each step is shown for ON_TICKS ticks, then blanked for
//   OFF_TICKS ticks. Sits between the game FSM (START/DONE) and the LED output mux.
// PARAMETERS
//   LEN_W     4   sequence address width; max sequence length 2**LEN_W
//   ON_TW     4   width of the on/off tick counters
//   ON_TICKS  8   TICK_i pulses a colour is lit (1..2**ON_TW-1)
//   OFF_TICKS 4   TICK_i pulses of blank gap after each colour (1..2**ON_TW-1)
// PORTS
//   CLK_i       in   1      system clock, all state on rising edge
//   RSTN_i      in   1      asynchronous active-low reset
//   START_i     in   1      1-cycle pulse: begin playback (sampled only in IDLE)
//   LAST_i      in   LEN_W  index of last step to play (steps = LAST_i+1), sampled at START
//   TICK_i      in   1      1-cycle time-base enable (from game prescaler)
//   SEQ_ADDR_o  out  LEN_W  sequence RAM read address
//   SEQ_DATA_i  in   2      colour code from RAM, valid 1 cycle after SEQ_ADDR_o
//   SEL_o       out  2      colour select to mux (00 green,01 red,10 yellow,11 blue)
//   BLANK_o     out  1      1 = LEDs off (gates mux output), 0 = show SEL_o colour
//   BUSY_o      out  1      1 from cycle after accepted START until DONE_o
//   DONE_o      out  1      1-cycle pulse when final gap completes
// BEHAVIOUR
//   Reset: state IDLE; SEQ_ADDR_o=0, SEL_o=00, BLANK_o=1, BUSY_o=0, DONE_o=0, counters 0.
//   FSM states: IDLE -> FETCH -> SHOW -> GAP -> (FETCH | FINISH) -> IDLE.
//   IDLE: BLANK_o=1. START_i=1 -> latch LAST_i into last_q, SEQ_ADDR_o<=0, go FETCH.
//   FETCH: 1 cycle, waits on RAM latency. Next edge: SEL_o<=SEQ_DATA_i, BLANK_o<=0,
//     tick counter<=0, go SHOW.
//   SHOW: count TICK_i pulses; on the ON_TICKS-th pulse set BLANK_o<=1, cnt<=0, go GAP.
//     SEL_o holds its value during SHOW and GAP.
//   GAP: count TICK_i pulses. On the OFF_TICKS-th pulse:
//     if SEQ_ADDR_o==last_q -> go FINISH; else SEQ_ADDR_o<=+1, go FETCH.
//   FINISH: DONE_o=1 for exactly one cycle, BUSY_o<=0, go IDLE.
//   BUSY_o=1 in FETCH/SHOW/GAP, 0 in IDLE/FINISH (registered).
//   START_i outside IDLE is ignored. LAST_i changes after START have no effect.
//   TICK_i during FETCH is not counted. TICK_i coinciding with a state-entry edge is
//     not counted: counting begins the cycle after entry.
//   LAST_i=0: single step, then DONE. LAST_i=all-ones: plays 2**LEN_W steps with no
//     address wrap (compare happens before increment).
//   Tick counters are ON_TW wide and saturate-free: they clear on every state change.
//   RSTN_i low mid-playback: immediate return to reset values. No DONE_o pulse.
//   All outputs come from registers; no combinational path from inputs to outputs.
// STRUCTURE
//   Shared package/include genius_defs: colour codes (GREEN=2'b00..BLUE=2'b11),
//     FSM state encoding (3-bit localparams), LEN_W default.
//   One sub-module: genius_tick_counter (clear, TICK_i enable, terminal-count compare,
//     count/terminal outputs), instantiated once. The FSM picks its ON or OFF terminal.
// TESTING
//   1 Reset mid-SHOW (RSTN_i low 1 cycle) -> BLANK_o=1, BUSY_o=0, SEQ_ADDR_o=0 at once;
//     no DONE_o.
//   2 RAM={01,11,00}, LAST_i=2, TICK_i every 4 cycles -> SEL_o 01,11,00 in order.
//     BLANK_o low 8 ticks, high 4 ticks per step. DONE_o one pulse after the 3rd gap.
//   3 LAST_i=0 -> SEQ_ADDR_o stays 0, one SHOW+GAP, DONE_o pulse, BUSY_o high 1+8+4
//     ticks' worth.
//   4 LAST_i=15 -> addresses 0..15 each read exactly once, no wrap to 0 before DONE_o.
//   5 START_i pulses during SHOW and GAP -> ignored, sequence and timing unchanged.
//   6 TICK_i held high continuously -> SHOW lasts exactly 8 cycles, GAP exactly 4 cycles.
//     START_i and TICK_i in the same cycle do not shorten the first SHOW.

Source files
------------

// File: rtl/genius_defs.sv
// Shared definitions for the Genius game blocks:
// colour codes, playback FSM encoding and default widths.
package genius_defs;

   localparam int LEN_W = 4;
   localparam int ON_TW = 4;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] RED    = 2'b01;
   localparam logic [1:0] YELLOW = 2'b10;
   localparam logic [1:0] BLUE   = 2'b11;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_SHOW   = 3'd2;
   localparam logic [2:0] ST_GAP    = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      FETCH  = ST_FETCH,
      SHOW   = ST_SHOW,
      GAP    = ST_GAP,
      FINISH = ST_FINISH
   } state_t;

endpackage

// File: rtl/genius_tick_counter.sv
// Counts time-base ticks; flags the tick that reaches the
// selected terminal count so the FSM can leave its state.
module genius_tick_counter
   import genius_defs::*;
#(
   parameter int W = ON_TW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         hit
);

   logic [W-1:0] count;

   // hit marks the term-th tick itself, not the cycle after it
   assign hit = en && (count == term - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/genius_seq_player.sv
// Plays the stored colour sequence: each step lit for ON_TICKS
// ticks, then blanked for OFF_TICKS ticks, then DONE pulse.
module genius_seq_player
   import genius_defs::*;
#(
   parameter int LEN_W     = genius_defs::LEN_W,
   parameter int ON_TW     = genius_defs::ON_TW,
   parameter int ON_TICKS  = 8,
   parameter int OFF_TICKS = 4
) (
   input  logic             CLK_i,
   input  logic             RSTN_i,
   input  logic             START_i,
   input  logic [LEN_W-1:0] LAST_i,
   input  logic             TICK_i,
   output logic [LEN_W-1:0] SEQ_ADDR_o,
   input  logic [1:0]       SEQ_DATA_i,
   output logic [1:0]       SEL_o,
   output logic             BLANK_o,
   output logic             BUSY_o,
   output logic             DONE_o
);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0] last_q, last_d;
   logic [1:0]       sel_q, sel_d;
   logic             blank_q, blank_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_hit;
   logic [ON_TW-1:0] cnt_term;

   localparam logic [ON_TW-1:0] ON_T  = ON_TW'(ON_TICKS);
   localparam logic [ON_TW-1:0] OFF_T = ON_TW'(OFF_TICKS);

   assign cnt_en   = TICK_i && (state_q == SHOW || state_q == GAP);
   assign cnt_clr  = (state_d != state_q);
   assign cnt_term = (state_q == SHOW) ? ON_T : OFF_T;

   genius_tick_counter #(
      .W(ON_TW)
   ) u_cnt (
      .clk  (CLK_i),
      .rst_n(RSTN_i),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .term (cnt_term),
      .hit  (cnt_hit)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      last_d  = last_q;
      sel_d   = sel_q;
      blank_d = blank_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            blank_d = 1'b1;
            busy_d  = 1'b0;
            if (START_i) begin
               last_d  = LAST_i;
               addr_d  = '0;
               busy_d  = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            sel_d   = SEQ_DATA_i;
            blank_d = 1'b0;
            state_d = SHOW;
         end
         SHOW: begin
            if (cnt_hit) begin
               blank_d = 1'b1;
               state_d = GAP;
            end
         end
         GAP: begin
            // compare before increment: LAST=all-ones never wraps
            if (cnt_hit) begin
               if (addr_q == last_q) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = FINISH;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_i or negedge RSTN_i) begin
      if (!RSTN_i) begin
         state_q <= IDLE;
         addr_q  <= '0;
         last_q  <= '0;
         sel_q   <= GREEN;
         blank_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
         blank_q <= blank_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign SEQ_ADDR_o = addr_q;
   assign SEL_o      = sel_q;
   assign BLANK_o    = blank_q;
   assign BUSY_o     = busy_q;
   assign DONE_o     = done_q;

endmodule

// File: tb/tb_genius_seq_player.sv
// Directed bench for genius_seq_player: table of playback runs
// plus hand-written reset and pulse-width sequences.
module tb_genius_seq_player;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] last_in = 4'd0;
   logic [3:0] addr;
   logic [1:0] data;
   logic [1:0] sel;
   logic       blank;
   logic       busy;
   logic       done;
   logic [1:0] ram [16];

   int n_vec = 0;
   int n_bad = 0;

   assign data = ram[addr];

   always #5 clk = ~clk;

   genius_seq_player dut (
      .CLK_i     (clk),
      .RSTN_i    (rst_n),
      .START_i   (start),
      .LAST_i    (last_in),
      .TICK_i    (tick),
      .SEQ_ADDR_o(addr),
      .SEQ_DATA_i(data),
      .SEL_o     (sel),
      .BLANK_o   (blank),
      .BUSY_o    (busy),
      .DONE_o    (done)
   );

   typedef struct {
      logic [3:0]  last;
      int          per;
      logic [31:0] pat;
      bit          pokes;
      int          steps;
      int          busy_cyc;
      int          low_cyc;
   } vec_t;

   vec_t vt [5];

   task automatic chk(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic run(input vec_t v, input int id);
      int   c, falls, busy_c, low_c, decs;
      logic pb;
      logic [3:0] pa;
      bit   seen;
      for (int i = 0; i < 16; i++) ram[i] = v.pat[2*i +: 2];
      @(posedge clk); #1;
      start = 1'b1;
      last_in = v.last;
      tick = (v.per == 1);
      @(posedge clk); #1;
      start = 1'b0;
      last_in = ~v.last;
      c = 0; falls = 0; busy_c = 0; low_c = 0; decs = 0;
      pb = 1'b1; pa = 4'd0; seen = 1'b0;
      while (!seen && c < 3000) begin
         tick = (v.per == 1) || (c % 4 == 3);
         start = v.pokes && (c == 5 || c == 10 || c == 20 || c == 40);
         @(negedge clk);
         if (busy) busy_c++;
         if (!blank) low_c++;
         if (pb && !blank) begin
            chk($sformatf("v%0d sel step%0d", id, falls),
                int'(sel), int'(ram[falls % 16]));
            chk($sformatf("v%0d addr step%0d", id, falls),
                int'(addr), falls);
            falls++;
         end
         if (busy && addr < pa) decs++;
         if (busy) pa = addr;
         if (done) begin
            seen = 1'b1;
            chk($sformatf("v%0d busy at done", id), int'(busy), 0);
            chk($sformatf("v%0d addr at done", id), int'(addr),
                int'(v.last));
         end
         pb = blank;
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      tick = 1'b0;
      chk($sformatf("v%0d done seen", id), int'(seen), 1);
      chk($sformatf("v%0d steps", id), falls, v.steps);
      chk($sformatf("v%0d busy cycles", id), busy_c, v.busy_cyc);
      chk($sformatf("v%0d lit cycles", id), low_c, v.low_cyc);
      chk($sformatf("v%0d addr wraps", id), decs, 0);
      @(negedge clk);
      chk($sformatf("v%0d done width", id), int'(done), 0);
      chk($sformatf("v%0d idle busy", id), int'(busy), 0);
      chk($sformatf("v%0d idle blank", id), int'(blank), 1);
   endtask

   initial begin
      int dn, bz;
      vt[0] = '{4'd2,  4, 32'h0000_000D, 1'b1, 3,  144, 93};
      vt[1] = '{4'd0,  1, 32'h0000_0002, 1'b0, 1,  13,  8};
      vt[2] = '{4'd15, 1, 32'h1B4E_93C6, 1'b1, 16, 208, 128};
      vt[3] = '{4'd2,  1, 32'h0000_00E4, 1'b1, 3,  39,  24};
      vt[4] = '{4'd0,  4, 32'h0000_0003, 1'b0, 1,  48,  31};
      for (int i = 0; i < 16; i++) ram[i] = 2'b00;

      #12;
      chk("reset addr", int'(addr), 0);
      chk("reset sel", int'(sel), 0);
      chk("reset blank", int'(blank), 1);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run(vt[i], i);

      // reset in the middle of the second step's SHOW
      for (int i = 0; i < 16; i++) ram[i] = 2'(i + 1);
      @(posedge clk); #1;
      start = 1'b1;
      last_in = 4'd2;
      tick = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      chk("pre-reset addr", int'(addr), 1);
      chk("pre-reset blank", int'(blank), 0);
      rst_n = 1'b0;
      #1;
      chk("rst addr", int'(addr), 0);
      chk("rst blank", int'(blank), 1);
      chk("rst busy", int'(busy), 0);
      chk("rst sel", int'(sel), 0);
      chk("rst done", int'(done), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      dn = 0;
      bz = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) dn++;
         if (busy) bz++;
      end
      tick = 1'b0;
      chk("post-rst done", dn, 0);
      chk("post-rst busy", bz, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
